// File: rtl/ex_div.sv
// ex_div: iterative 32-bit restoring divider for the EX stage.
// Handles DIV (signed) and DIVU (unsigned). A request is accepted from
// DIV_FREE, takes one quotient bit per cycle, and parks the result in
// DIV_END until EX releases i_start. Divide-by-zero skips the iterations
// and returns zero. i_annul aborts from any state; i_rst clears everything.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_signed,
  input  logic [DATA_W-1:0]     i_opdata1,
  input  logic [DATA_W-1:0]     i_opdata2,
  input  logic                  i_start,
  input  logic                  i_annul,
  output logic [2*DATA_W-1:0]   o_result,
  output logic                  o_ready,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic [5:0] LAST_CNT = 6'(DATA_W);

  div_state_t          state;
  div_state_t          state_nxt;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   quot_q;     // dividend shifts out MSB-first, quotient shifts in LSB
  logic [DATA_W-1:0]   rem_q;      // partial remainder
  logic [DATA_W-1:0]   dsr_q;      // captured divisor magnitude
  logic                neg_quot;
  logic                neg_rem;

  logic [DATA_W-1:0]   shl;
  logic [DATA_W:0]     trial;
  logic                fits;
  logic                accept;

  // Two's-complement negate when requested; used for operand magnitudes and
  // result sign correction. Wraps for the most negative value by design.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                input logic en);
    logic signed [DATA_W-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  assign accept = i_start && !i_annul;

  // The shifted remainder is 33 bits: {rem_q, next dividend bit}. Its top bit
  // is rem_q[MSB]; when set the value already exceeds any 32-bit divisor, so
  // the trial only needs the lower 32 bits plus a borrow.
  assign shl   = {rem_q[DATA_W-2:0], quot_q[DATA_W-1]};
  assign trial = {1'b0, shl} - {1'b0, dsr_q};
  assign fits  = rem_q[DATA_W-1] | ~trial[DATA_W];

  assign o_busy = (state == DIV_ON) || (state == DIV_BYZERO);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= DIV_FREE;
    else       state <= state_nxt;
  end

  // Next-state decode; annul wins over every other condition
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_FREE: begin
        if (accept) state_nxt = (i_opdata2 == '0) ? DIV_BYZERO : DIV_ON;
      end
      DIV_BYZERO: begin
        state_nxt = i_annul ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (i_annul)               state_nxt = DIV_FREE;
        else if (cnt == LAST_CNT)  state_nxt = DIV_END;
      end
      DIV_END: begin
        if (i_annul || !i_start)   state_nxt = DIV_FREE;
      end
      default: state_nxt = DIV_FREE;
    endcase
  end

  // Operand capture, one restoring iteration per cycle, and result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      o_result <= '0;
      o_ready  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          cnt      <= '0;
          o_ready  <= 1'b0;
          o_result <= '0;
          if (accept) begin
            quot_q   <= neg_if(i_opdata1, i_signed & i_opdata1[DATA_W-1]);
            dsr_q    <= neg_if(i_opdata2, i_signed & i_opdata2[DATA_W-1]);
            rem_q    <= '0;
            neg_quot <= i_signed & (i_opdata1[DATA_W-1] ^ i_opdata2[DATA_W-1]);
            neg_rem  <= i_signed & i_opdata1[DATA_W-1];
          end
        end
        DIV_BYZERO: begin
          cnt      <= '0;
          o_result <= '0;
          o_ready  <= !i_annul;
        end
        DIV_ON: begin
          if (i_annul) begin
            cnt      <= '0;
            o_ready  <= 1'b0;
            o_result <= '0;
          end else if (cnt == LAST_CNT) begin
            o_ready  <= 1'b1;
            o_result <= {neg_if(rem_q, neg_rem), neg_if(quot_q, neg_quot)};
          end else begin
            rem_q  <= fits ? trial[DATA_W-1:0] : shl;
            quot_q <= {quot_q[DATA_W-2:0], fits};
            cnt    <= cnt + 6'd1;
          end
        end
        DIV_END: begin
          if (i_annul || !i_start) begin
            cnt      <= '0;
            o_ready  <= 1'b0;
            o_result <= '0;
          end
        end
        default: begin
          cnt      <= '0;
          o_ready  <= 1'b0;
          o_result <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed-vector bench for ex_div with hand-computed results.
module tb_ex_div;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_signed;
  logic [31:0] i_opdata1;
  logic [31:0] i_opdata2;
  logic        i_start;
  logic        i_annul;
  logic [63:0] o_result;
  logic        o_ready;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  ex_div dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_signed  (i_signed),
    .i_opdata1 (i_opdata1),
    .i_opdata2 (i_opdata2),
    .i_start   (i_start),
    .i_annul   (i_annul),
    .o_result  (o_result),
    .o_ready   (o_ready),
    .o_busy    (o_busy)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Accept a request, run to o_ready, optionally hold i_start in DIV_END,
  // then release. With scramble set, operands and i_signed change after the
  // acceptance edge and i_start drops for a few cycles mid-run.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int lat, input bit scramble, input int hold);
    int edges;
    int busy_cnt;
    i_signed  = sgn;
    i_opdata1 = a;
    i_opdata2 = b;
    i_start   = 1'b1;
    tick();
    edges    = 0;
    busy_cnt = 0;
    if (scramble) begin
      i_opdata1 = ~a;
      i_opdata2 = 32'h3;
      i_signed  = ~sgn;
    end
    while (!o_ready && edges < 40) begin
      if (o_busy) busy_cnt++;
      if (scramble && edges == 5)  i_start = 1'b0;
      if (scramble && edges == 10) i_start = 1'b1;
      tick();
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_result"}, o_result, exp);
    check({tag, "_busy_end"}, 64'(o_busy), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_ready"}, 64'(o_ready), 64'd1);
      check({tag, "_hold_result"}, o_result, exp);
    end
    i_start = 1'b0;
    tick();
    check({tag, "_rel_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_rel_result"}, o_result, 64'd0);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (o_ready || o_busy) seen = 1'b1;
    end
    check({tag, "_no_activity"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vecs[3]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 33};
    vecs[4]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
    vecs[5]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'h80000001,   64'h7FFFFFFE_00000001, 33};
    vecs[8]  = '{1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF,   64'hFFFFFFFE_00000000, 33};
    vecs[9]  = '{1'b0, 32'd12345,      32'd0,          64'h00000000_00000000, 1};
    vecs[10] = '{1'b1, 32'h80000000,   32'd0,          64'h00000000_00000000, 1};
    vecs[11] = '{1'b0, 32'd5,          32'hFFFFFFFF,   64'h00000005_00000000, 33};

    i_rst     = 1'b1;
    i_signed  = 1'b0;
    i_opdata1 = '0;
    i_opdata2 = '0;
    i_start   = 1'b0;
    i_annul   = 1'b0;
    tick();
    tick();
    check("reset_result", o_result, 64'd0);
    check("reset_ready", 64'(o_ready), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    i_rst = 1'b0;
    tick();

    for (int v = 0; v < 12; v++)
      run_div($sformatf("vec%0d", v), vecs[v].sgn, vecs[v].a, vecs[v].b,
              vecs[v].exp, vecs[v].lat, 1'b0, 0);

    // Operands and i_signed change after acceptance; i_start dips mid-run
    run_div("scramble", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b1, 0);

    // Result held while i_start stays high in DIV_END
    run_div("hold5", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 1'b0, 5);

    // Abort mid-division: annul seen on edge E11
    i_signed  = 1'b0;
    i_opdata1 = 32'h12345678;
    i_opdata2 = 32'd3;
    i_start   = 1'b1;
    tick();
    repeat (10) tick();
    check("annul_busy_before", 64'(o_busy), 64'd1);
    i_annul = 1'b1;
    i_start = 1'b0;
    tick();
    check("annul_busy", 64'(o_busy), 64'd0);
    check("annul_ready", 64'(o_ready), 64'd0);
    check("annul_result", o_result, 64'd0);
    i_annul = 1'b0;
    expect_idle("annul", 40);
    run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 1'b0, 0);

    // Reset at E15 with operands changed after acceptance
    i_signed  = 1'b1;
    i_opdata1 = 32'hFFFFFFF9;
    i_opdata2 = 32'd2;
    i_start   = 1'b1;
    tick();
    i_opdata1 = 32'h00000064;
    i_opdata2 = 32'h00000009;
    repeat (14) tick();
    i_rst = 1'b1;
    tick();
    check("rst_mid_result", o_result, 64'd0);
    check("rst_mid_ready", 64'(o_ready), 64'd0);
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    expect_idle("rst_mid", 40);
    run_div("after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0, 0);

    // Start together with annul in DIV_FREE must not be accepted
    i_signed  = 1'b0;
    i_opdata1 = 32'd50;
    i_opdata2 = 32'd5;
    i_start   = 1'b1;
    i_annul   = 1'b1;
    expect_idle("start_annul", 5);
    i_opdata2 = 32'd0;
    expect_idle("start_annul_zero", 5);
    i_start = 1'b0;
    i_annul = 1'b0;
    tick();

    // Back-to-back requests after release
    run_div("b2b_a", 1'b0, 32'd81, 32'd9, 64'h00000000_00000009, 33, 1'b0, 0);
    run_div("b2b_b", 1'b1, 32'hFFFFFFF9, 32'd0, 64'h00000000_00000000, 1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
